// File: rtl/kn_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kn_sched_pkg
//  Description : Shared types and constants for the K_n term scheduler:
//                scheduler state encoding, default datapath widths, the
//                term width and the buffered scan-point layout.
//  Revision    : 1.0  initial release
// ============================================================================
package kn_sched_pkg;

   localparam int c_DW_INTEGER = 18;
   localparam int c_DW_FRACTION = 6;
   localparam int c_DW_INPUT = 8;
   localparam int c_ANGLE_DW = 8;

   // Signed term width: integer + fraction + sign.
   localparam int TERM_W = c_DW_INTEGER + c_DW_FRACTION + 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_START    = 3'd1,
      S_WAIT_RES = 3'd2,
      S_HOLD     = 3'd3,
      S_ACK      = 3'd4,
      S_DONE     = 3'd5,
      S_ABORT    = 3'd6
   } sched_state_t;

   typedef struct packed {
      logic [c_DW_INPUT+3:0] r0;
      logic [c_ANGLE_DW-1:0] angle;
   } scan_point_t;

   function automatic int term_width(input int dw_int, input int dw_frac);
      return dw_int + dw_frac + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/kn_term_scheduler_sp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sp_fifo
//  Description : Synchronous FIFO with full/empty flags and a combinational
//                (first-word fall-through) read port. A write while full is
//                accepted when a read happens in the same cycle.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                i_wr_en, i_wr_data  write request and data
//                i_rd_en, o_rd_data  read request and head-of-queue data
//                o_full, o_empty     occupancy flags
//  Revision    : 1.0  initial release
// ============================================================================
module sp_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4    // power of 2, >= 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int c_AW = $clog2(DEPTH);
   localparam logic [c_AW:0] c_DEPTH = (c_AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;
   logic             w_do_wr;
   logic             w_do_rd;

   assign o_full    = (r_count == c_DEPTH);
   assign o_empty   = (r_count == '0);
   assign w_do_rd   = i_rd_en && !o_empty;
   assign w_do_wr   = i_wr_en && (!o_full || w_do_rd);
   assign o_rd_data = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_wr) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/kn_term_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : kn_term_scheduler
//  Description : Sequences the K_n increment-term calculator over a stream of
//                buffered scan points. Pops a point, pulses calc_initiate,
//                forwards each element's term pair downstream over
//                valid/ready, acknowledges the calculator after each accepted
//                beat, and aborts a hung calculation after TIMEOUT_CYCLES.
//  Ports       : clk, rst                       clock, sync active-high reset
//                sp_valid/sp_ready/sp_r0/sp_angle  scan-point input
//                calc_*                         calculator handshake + data
//                out_*                          term-pair output stream
//                busy, err_timeout, err_count   status / sticky errors
//  Revision    : 1.0  initial release
// ============================================================================
module kn_term_scheduler
   import kn_sched_pkg::*;
#(
   parameter int DW_INTEGER     = c_DW_INTEGER,
   parameter int DW_FRACTION    = c_DW_FRACTION,
   parameter int DW_INPUT       = c_DW_INPUT,
   parameter int ANGLE_DW       = c_ANGLE_DW,
   parameter int NUM_ELEMENTS   = 33,
   parameter int QUEUE_DEPTH    = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         sp_valid,
   output logic                                         sp_ready,
   input  logic [DW_INPUT+3:0]                          sp_r0,
   input  logic [ANGLE_DW-1:0]                          sp_angle,
   output logic                                         calc_initiate,
   output logic                                         calc_ack,
   output logic                                         calc_rst,
   output logic [DW_INPUT+3:0]                          calc_r0,
   output logic [ANGLE_DW-1:0]                          calc_angle,
   input  logic                                         calc_ready,
   input  logic                                         calc_last,
   input  logic signed [DW_INTEGER+DW_FRACTION:0]       calc_term_pos,
   input  logic signed [DW_INTEGER+DW_FRACTION:0]       calc_term_neg,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic signed [DW_INTEGER+DW_FRACTION:0]       out_term_pos,
   output logic signed [DW_INTEGER+DW_FRACTION:0]       out_term_neg,
   output logic [$clog2(NUM_ELEMENTS)-1:0]              out_elem_idx,
   output logic                                         out_last,
   output logic [7:0]                                   out_scan_idx,
   output logic                                         busy,
   output logic                                         err_timeout,
   output logic                                         err_count
);

   localparam int c_TERM_W = term_width(DW_INTEGER, DW_FRACTION);
   localparam int c_R0_W   = DW_INPUT + 4;
   localparam int c_SP_W   = c_R0_W + ANGLE_DW;
   localparam int c_IDX_W  = $clog2(NUM_ELEMENTS);
   localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_ELEMENTS - 1);
   localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);

   sched_state_t        r_state;
   sched_state_t        w_state_nxt;
   logic                w_push;
   logic                w_pop;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic [c_SP_W-1:0]   w_fifo_rd_data;
   logic [c_IDX_W-1:0]  r_elem_idx;
   logic [c_TO_W-1:0]   r_to_cnt;
   logic                w_at_last_idx;

   assign sp_ready      = !w_fifo_full;
   assign w_push        = sp_valid && sp_ready;
   assign busy          = (r_state != S_IDLE) || !w_fifo_empty;
   assign w_at_last_idx = (r_elem_idx == c_LAST_IDX);

   sp_fifo #(
      .WIDTH (c_SP_W),
      .DEPTH (QUEUE_DEPTH)
   ) u_sp_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_push),
      .i_wr_data ({sp_r0, sp_angle}),
      .i_rd_en   (w_pop),
      .o_rd_data (w_fifo_rd_data),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pop         = 1'b0;
      calc_initiate = 1'b0;
      calc_ack      = 1'b0;
      calc_rst      = 1'b0;
      out_valid     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_fifo_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            calc_initiate = 1'b1;
            w_state_nxt   = S_WAIT_RES;
         end
         S_WAIT_RES: begin
            if (calc_ready)                w_state_nxt = S_HOLD;
            else if (r_to_cnt == c_TO_LAST) w_state_nxt = S_ABORT;
         end
         S_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = out_last ? S_DONE : S_ACK;
         end
         S_ACK: begin
            // The calculator still shows the previous result here, so
            // calc_ready is deliberately not looked at until WAIT_RES.
            calc_ack    = 1'b1;
            w_state_nxt = S_WAIT_RES;
         end
         S_DONE: begin
            calc_ack    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         S_ABORT: begin
            calc_rst    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         calc_r0      <= '0;
         calc_angle   <= '0;
         out_term_pos <= '0;
         out_term_neg <= '0;
         out_elem_idx <= '0;
         out_last     <= 1'b0;
         out_scan_idx <= '0;
         err_timeout  <= 1'b0;
         err_count    <= 1'b0;
         r_elem_idx   <= '0;
         r_to_cnt     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Operands are latched on pop and held for the whole scan.
               if (!w_fifo_empty) begin
                  calc_r0    <= w_fifo_rd_data[c_SP_W-1:ANGLE_DW];
                  calc_angle <= w_fifo_rd_data[ANGLE_DW-1:0];
               end
            end
            S_START: begin
               r_to_cnt   <= '0;
               r_elem_idx <= '0;
            end
            S_WAIT_RES: begin
               if (calc_ready) begin
                  out_term_pos <= calc_term_pos;
                  out_term_neg <= calc_term_neg;
                  out_elem_idx <= r_elem_idx;
                  // Final index always terminates the scan, even if the
                  // calculator failed to flag it.
                  out_last     <= calc_last || w_at_last_idx;
                  if (calc_last != w_at_last_idx) err_count <= 1'b1;
               end else if (r_to_cnt != c_TO_LAST) begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            S_ACK: begin
               r_elem_idx <= r_elem_idx + 1'b1;
               r_to_cnt   <= '0;
            end
            S_DONE: begin
               out_scan_idx <= out_scan_idx + 8'd1;
            end
            S_ABORT: begin
               err_timeout  <= 1'b1;
               out_scan_idx <= out_scan_idx + 8'd1;
            end
            default: ;
         endcase
      end
   end

   // Term width from the package helper must agree with the port width.
   logic [c_TERM_W-1:0] w_term_width_tie;
   assign w_term_width_tie = calc_term_pos ^ calc_term_neg;
   logic w_unused;
   assign w_unused = ^w_term_width_tie;

endmodule
`default_nettype wire

// File: tb/tb_kn_term_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kn_term_scheduler
//  Description : Self-checking bench for kn_term_scheduler. A behavioural
//                calculator stub answers initiate/ack with formula-generated
//                terms; a scan-point queue plus element counter predicts
//                every accepted output beat.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_kn_term_scheduler;
   import kn_sched_pkg::*;

   localparam int c_NE = 33;

   logic clk, rst;
   logic sp_valid, sp_ready;
   logic [11:0] sp_r0;
   logic [7:0]  sp_angle;
   logic calc_initiate, calc_ack, calc_rst;
   logic [11:0] calc_r0;
   logic [7:0]  calc_angle;
   logic calc_ready, calc_last;
   logic signed [TERM_W-1:0] calc_term_pos, calc_term_neg;
   logic out_valid, out_ready;
   logic signed [TERM_W-1:0] out_term_pos, out_term_neg;
   logic [5:0] out_elem_idx;
   logic out_last;
   logic [7:0] out_scan_idx;
   logic busy, err_timeout, err_count;

   kn_term_scheduler dut (
      .clk(clk), .rst(rst),
      .sp_valid(sp_valid), .sp_ready(sp_ready), .sp_r0(sp_r0), .sp_angle(sp_angle),
      .calc_initiate(calc_initiate), .calc_ack(calc_ack), .calc_rst(calc_rst),
      .calc_r0(calc_r0), .calc_angle(calc_angle),
      .calc_ready(calc_ready), .calc_last(calc_last),
      .calc_term_pos(calc_term_pos), .calc_term_neg(calc_term_neg),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_term_pos(out_term_pos), .out_term_neg(out_term_neg),
      .out_elem_idx(out_elem_idx), .out_last(out_last), .out_scan_idx(out_scan_idx),
      .busy(busy), .err_timeout(err_timeout), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Calculator model: A_0 and C_0 are arbitrary functions of the scan point
   // (r0=100, angle=30 gives A_0=1054, i.e. 2108 LSB step per element).
   function automatic longint f_a0(input logic [11:0] r0, input logic [7:0] ang);
      return longint'(r0) * 10 + longint'(ang) + 24;
   endfunction
   function automatic longint f_c0(input logic [11:0] r0, input logic [7:0] ang);
      return longint'(r0) * 3 + longint'(ang);
   endfunction
   function automatic longint f_pos(input logic [11:0] r0, input logic [7:0] ang, input int n);
      return f_a0(r0, ang) * (2 * n + 1) - f_c0(r0, ang);
   endfunction
   function automatic longint f_neg(input logic [11:0] r0, input logic [7:0] ang, input int n);
      return f_a0(r0, ang) * (2 * n + 1) + f_c0(r0, ang);
   endfunction

   // ---------------- calculator stub ----------------
   bit  stub_hang = 1'b0;
   int  stub_last_n = c_NE - 1;
   bit  stb_active;
   int  stb_n, stb_wait;
   logic [11:0] stb_r0;
   logic [7:0]  stb_ang;

   always @(posedge clk) begin
      if (rst || calc_rst) begin
         stb_active <= 1'b0;
         calc_ready <= 1'b0;
         calc_last  <= 1'b0;
         calc_term_pos <= '0;
         calc_term_neg <= '0;
      end else if (calc_initiate) begin
         stb_active <= 1'b1;
         stb_n      <= 0;
         stb_wait   <= int'($urandom_range(0, 3));
         stb_r0     <= calc_r0;
         stb_ang    <= calc_angle;
         calc_ready <= 1'b0;
      end else if (calc_ack) begin
         calc_ready <= 1'b0;
         if (calc_last) stb_active <= 1'b0;
         else begin
            stb_n    <= stb_n + 1;
            stb_wait <= int'($urandom_range(0, 3));
         end
      end else if (stb_active && !calc_ready && !stub_hang) begin
         if (stb_wait == 0) begin
            calc_ready    <= 1'b1;
            calc_last     <= (stb_n == stub_last_n);
            calc_term_pos <= TERM_W'(f_pos(stb_r0, stb_ang, stb_n));
            calc_term_neg <= TERM_W'(f_neg(stb_r0, stb_ang, stb_n));
         end else begin
            stb_wait <= stb_wait - 1;
         end
      end
   end

   // ---------------- out_ready driver ----------------
   bit bp_mode = 1'b0;
   bit ready_fixed = 1'b1;
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         out_ready = bp_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model / monitor ----------------
   scan_point_t mq[$];
   int  m_n = 0, m_scan = 0;
   int  beats = 0, acks = 0;
   bit  prev_hold = 0, prev_acc = 0;
   longint prev_pos, prev_neg, prev_idx, prev_last;

   always @(negedge clk) begin
      if (rst) begin
         mq.delete();
         m_n = 0; m_scan = 0; prev_hold = 0; prev_acc = 0;
      end else begin
         if (prev_hold && out_valid) begin
            chk("hold_pos",  longint'(out_term_pos), prev_pos);
            chk("hold_neg",  longint'(out_term_neg), prev_neg);
            chk("hold_idx",  longint'(out_elem_idx), prev_idx);
            chk("hold_last", longint'(out_last), prev_last);
         end
         chk("ack_follows_accept", longint'(calc_ack), longint'(prev_acc));
         if (calc_ack) acks++;
         if (calc_initiate && mq.size() > 0) begin
            chk("calc_r0",    longint'(calc_r0),    longint'(mq[0].r0));
            chk("calc_angle", longint'(calc_angle), longint'(mq[0].angle));
         end
         if (calc_rst) begin
            if (mq.size() > 0) void'(mq.pop_front());
            m_n = 0;
            m_scan++;
         end
         if (out_valid && out_ready) begin
            beats++;
            if (mq.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               automatic bit exp_last = (m_n == stub_last_n) || (m_n == c_NE - 1);
               chk("out_term_pos", longint'(out_term_pos), f_pos(mq[0].r0, mq[0].angle, m_n));
               chk("out_term_neg", longint'(out_term_neg), f_neg(mq[0].r0, mq[0].angle, m_n));
               chk("out_elem_idx", longint'(out_elem_idx), longint'(m_n));
               chk("out_last",     longint'(out_last), longint'(exp_last));
               chk("out_scan_idx", longint'(out_scan_idx), longint'(m_scan % 256));
               if (exp_last) begin
                  void'(mq.pop_front());
                  m_n = 0;
                  m_scan++;
               end else begin
                  m_n++;
               end
            end
         end
         prev_acc  = out_valid && out_ready;
         prev_hold = out_valid && !out_ready;
         prev_pos  = longint'(out_term_pos);
         prev_neg  = longint'(out_term_neg);
         prev_idx  = longint'(out_elem_idx);
         prev_last = longint'(out_last);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; sp_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Call at posedge+#1; returns at posedge+#1 one cycle later.
   task automatic drive_sp(input logic [11:0] r0, input logic [7:0] ang, output bit acc);
      scan_point_t sp;
      sp_valid = 1'b1; sp_r0 = r0; sp_angle = ang;
      @(negedge clk);
      acc = sp_ready;
      if (acc) begin
         sp.r0 = r0; sp.angle = ang;
         mq.push_back(sp);
      end
      @(posedge clk); #1;
      sp_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      bit done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1;
      end
      chk({tag, "_idle_reached"}, longint'(done), 1);
      chk({tag, "_model_drained"}, longint'(mq.size()), 0);
   endtask

   task automatic wait_sig(input string tag, input int budget, input int which, output bit seen);
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         case (which)
            0: seen = calc_initiate;
            1: seen = calc_rst;
            2: seen = out_valid && (out_elem_idx == 6'd4) && out_ready;
            default: seen = out_valid && (out_elem_idx == 6'd5);
         endcase
      end
      if (!seen) chk({tag, "_wait_expired"}, 0, 1);
   endtask

   initial begin
      bit acc, seen;
      int b0, t0, a0;
      rst = 1'b1; sp_valid = 1'b0; sp_r0 = '0; sp_angle = '0;

      // ---- reset state ----
      do_reset();
      @(negedge clk);
      chk("rst_sp_ready", longint'(sp_ready), 1);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_initiate", longint'(calc_initiate), 0);
      chk("rst_ack", longint'(calc_ack), 0);
      chk("rst_calc_rst", longint'(calc_rst), 0);
      chk("rst_scan_idx", longint'(out_scan_idx), 0);
      chk("rst_err", longint'({err_timeout, err_count}), 0);

      // ---- single scan point, initiate latency ----
      @(posedge clk); #1;
      b0 = beats;
      drive_sp(12'd100, 8'd30, acc);
      chk("t1_accept", longint'(acc), 1);
      @(negedge clk);
      chk("t1_initiate_early", longint'(calc_initiate), 0);
      @(negedge clk);
      chk("t1_initiate_lat2", longint'(calc_initiate), 1);
      wait_idle("t1", 2000);
      chk("t1_beats", longint'(beats - b0), c_NE);
      chk("t1_err", longint'({err_timeout, err_count}), 0);

      // ---- FIFO fill with random back-pressure ----
      do_reset();
      bp_mode = 1'b1;
      b0 = beats;
      for (int i = 0; i < 5; i++) begin
         drive_sp(12'($urandom), 8'($urandom), acc);
         chk("t2_burst_accept", longint'(acc), 1);
      end
      drive_sp(12'd7, 8'd7, acc);
      chk("t2_full_refused", longint'(acc), 0);
      wait_idle("t2", 20000);
      chk("t2_beats", longint'(beats - b0), 5 * c_NE);
      chk("t2_acks_eq_beats", longint'(acks), longint'(beats));
      bp_mode = 1'b0;

      // ---- timeout / abort ----
      do_reset();
      stub_hang = 1'b1;
      b0 = beats;
      drive_sp(12'($urandom), 8'($urandom), acc);
      drive_sp(12'($urandom), 8'($urandom), acc);
      wait_sig("t3_init", 10, 0, seen);
      t0 = cyc;
      wait_sig("t3_abort", 200, 1, seen);
      stub_hang = 1'b0;
      chk("t3_abort_window", longint'((cyc - t0) >= 63 && (cyc - t0) <= 66), 1);
      @(negedge clk);
      chk("t3_err_timeout", longint'(err_timeout), 1);
      wait_idle("t3", 2000);
      chk("t3_beats_second", longint'(beats - b0), c_NE);
      chk("t3_err_timeout_sticky", longint'(err_timeout), 1);
      chk("t3_err_count", longint'(err_count), 0);

      // ---- early calc_last ----
      do_reset();
      stub_last_n = 10;
      b0 = beats;
      @(posedge clk); #1;
      drive_sp(12'($urandom), 8'($urandom), acc);
      wait_idle("t4", 2000);
      chk("t4_beats", longint'(beats - b0), 11);
      chk("t4_err_count", longint'(err_count), 1);
      chk("t4_err_timeout", longint'(err_timeout), 0);

      // ---- missing calc_last: forced at final element ----
      do_reset();
      stub_last_n = 40;
      b0 = beats;
      @(posedge clk); #1;
      drive_sp(12'($urandom), 8'($urandom), acc);
      wait_idle("t5", 2000);
      chk("t5_beats", longint'(beats - b0), c_NE);
      chk("t5_err_count", longint'(err_count), 1);
      stub_last_n = c_NE - 1;

      // ---- reset while holding element 5 ----
      do_reset();
      ready_fixed = 1'b1;
      @(posedge clk); #1;
      drive_sp(12'($urandom), 8'($urandom), acc);
      drive_sp(12'($urandom), 8'($urandom), acc);
      wait_sig("t6_idx4", 500, 2, seen);
      ready_fixed = 1'b0;
      wait_sig("t6_idx5", 500, 3, seen);
      a0 = acks;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_out_valid", longint'(out_valid), 0);
      chk("t6_busy_fifo_empty", longint'(busy), 0);
      chk("t6_sp_ready", longint'(sp_ready), 1);
      chk("t6_elem_idx", longint'(out_elem_idx), 0);
      chk("t6_terms", longint'(out_term_pos) | longint'(out_term_neg), 0);
      chk("t6_calc_r0", longint'(calc_r0), 0);
      chk("t6_ctrl", longint'({calc_initiate, calc_ack, calc_rst, out_last}), 0);
      repeat (10) @(negedge clk);
      chk("t6_no_ack", longint'(acks - a0), 0);
      chk("t6_still_idle", longint'(busy), 0);
      ready_fixed = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
